dif_radix2_64p_sdf_bf: RTL



---
 rtl/fft64_pkg.sv | 18 +
 rtl/sdf_delay_line.sv | 29 ++
 rtl/dif_radix2_64p_sdf_bf.sv | 95 +++++++++
 3 files changed

// File: rtl/fft64_pkg.sv
// Shared constants for the 64-point radix-2 DIF pipeline stages.
package fft64_pkg;

    localparam int FFT_POINTS        = 64;
    localparam int CNT_W             = $clog2(FFT_POINTS);
    localparam int DATA_WIDTH_IN_DEF = 10;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_e;

    // One growth bit per radix-2 stage.
    function automatic int out_width(input int win);
        return win + 1;
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Read-before-write circular feedback store for an SDF stage; DEPTH_LOG2=0 is a single register.
module sdf_delay_line #(
    parameter int WIDTH      = 22,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                                        clk,
    input  logic                                        en,
    input  logic [((DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1)-1:0] ptr,
    input  logic [WIDTH-1:0]                            wdata,
    output logic [WIDTH-1:0]                            rdata
);

    generate
        if (DEPTH_LOG2 == 0) begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk) begin
                if (en) q <= wdata;
            end
            assign rdata = q;
        end else begin : g_ram
            logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
            always_ff @(posedge clk) begin
                if (en) mem[ptr] <= wdata;
            end
            assign rdata = mem[ptr];
        end
    endgenerate

endmodule

// File: rtl/dif_radix2_64p_sdf_bf.sv
// Radix-2 DIF single-path delay-feedback butterfly with frame-position tag for the twiddle stage.
module dif_radix2_64p_sdf_bf
    import fft64_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = DATA_WIDTH_IN_DEF,
    parameter int DATA_WIDTH_OUT = out_width(DATA_WIDTH_IN),
    parameter int STAGE_LOG2     = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             halt_ctrl,
    input  logic signed [DATA_WIDTH_IN-1:0]  din_real,
    input  logic signed [DATA_WIDTH_IN-1:0]  din_imag,
    output logic signed [DATA_WIDTH_OUT-1:0] dout_real,
    output logic signed [DATA_WIDTH_OUT-1:0] dout_imag,
    output logic                             dout_valid,
    output logic [CNT_W-1:0]                 tm64_ctrl
);

    localparam int DELAY = 1 << STAGE_LOG2;
    localparam int PTR_W = (STAGE_LOG2 > 0) ? STAGE_LOG2 : 1;
    localparam int DW    = DATA_WIDTH_OUT;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                primed_q, primed_d;
    phase_e              phase;
    logic [PTR_W-1:0]    ptr;
    logic [2*DW-1:0]     rdata, wdata;
    logic signed [DW-1:0] x_re, x_im, m_re, m_im;
    logic signed [DW-1:0] w_re, w_im, y_re, y_im;
    logic signed [DW-1:0] dout_real_d, dout_imag_d;

    generate
        if (STAGE_LOG2 > 0) begin : g_ptr
            assign ptr = cnt_q[STAGE_LOG2-1:0];
        end else begin : g_noptr
            assign ptr = '0;
        end
    endgenerate

    assign x_re  = DW'(din_real);
    assign x_im  = DW'(din_imag);
    assign m_re  = rdata[2*DW-1:DW];
    assign m_im  = rdata[DW-1:0];
    assign wdata = {w_re, w_im};

    always_comb begin
        phase       = cnt_q[STAGE_LOG2] ? PH_BFLY : PH_FILL;
        cnt_d       = cnt_q + 1'b1;
        primed_d    = primed_q | (cnt_q == CNT_W'(DELAY - 1));
        w_re        = x_re;
        w_im        = x_im;
        y_re        = m_re;
        y_im        = m_im;
        if (phase == PH_BFLY) begin
            w_re = m_re - x_re;
            w_im = m_im - x_im;
            y_re = m_re + x_re;
            y_im = m_im + x_im;
        end
        // Until the line has been filled once, memory reads are uninitialised.
        dout_real_d = primed_q ? y_re : '0;
        dout_imag_d = primed_q ? y_im : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            dout_real  <= '0;
            dout_imag  <= '0;
            dout_valid <= 1'b0;
            tm64_ctrl  <= '0;
        end else if (halt_ctrl) begin
            cnt_q      <= cnt_d;
            primed_q   <= primed_d;
            dout_real  <= dout_real_d;
            dout_imag  <= dout_imag_d;
            dout_valid <= primed_q;
            tm64_ctrl  <= cnt_q;
        end
    end

    sdf_delay_line #(
        .WIDTH      (2 * DW),
        .DEPTH_LOG2 (STAGE_LOG2)
    ) u_delay (
        .clk   (clk),
        .en    (halt_ctrl & rst_n),
        .ptr   (ptr),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule
